acc_alu_sequencer: RTL and testbench
====================================

Name: acc_alu_sequencer

Overview:
- Accumulator-machine controller that sequences an external n-bit combinational ALU.
- Accepts one operation at a time over a start/done handshake, drives the ALU control and operand buses, and writes results and flags back into an internal accumulator.
- Adds a multi-cycle unsigned multiply built from repeated ALU ADD and shift passes.
- Sits between instruction decode and the ALU instance in the processor datapath.

Parameters:
- n, 8, datapath width of accumulator, operand and ALU buses.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- opcode  input  4  operation select, latched with start.
- operand  input  n  second operand, latched with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  illegal opcode on last op; updated with done.
- acc  output  n  accumulator.
- flag_V, flag_Z, flag_C  output  1 each  registered flags from last completed op.
- alu_cntrl  output  3  to ALU control.
- alu_in1, alu_in2  output  n each  to ALU inputs (in1 is the accumulator side).
- alu_out  input  n  from ALU.
- alu_V, alu_Z, alu_cout  input  1 each  from ALU.

Behaviour:
- Reset (async, any state, including mid-multiply): state IDLE; acc=0; flags=0; busy=0; done=0; err=0; alu_cntrl=3'b111; alu_in1=alu_in2=0. Any in-flight operation is aborted.
- ALU encoding: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 in1<<in2 (cout = bit shifted out), 101 in1>>in2, 110 ~in1, 111 pass in1.
- Opcodes:
  - 0ccc: ALU op ccc, with in1=acc and in2=operand_r.
  - 1000: LOAD, with cntrl 111 and in1=operand_r.
  - 1001: MUL.
  - 1010-1111: illegal.
- States: IDLE, EXEC, MUL_ADD, MUL_SHIFT, DONE.
- IDLE:
  - On start: latch op_r and operand_r.
  - MUL with operand 0: go to EXEC.
  - MUL with operand != 0: P=0, M=acc, Q=operand; go to MUL_ADD.
  - Otherwise: go to EXEC.
- Start outside IDLE is ignored, not queued.
- EXEC (1 cycle):
  - ALU op: acc<=alu_out; V/Z/C<=alu_V/alu_Z/alu_cout.
  - LOAD: acc<=operand_r; Z<=alu_Z; V=C=0.
  - MUL by 0: acc<=0; Z=1; V=C=0.
  - Illegal: acc and flags unchanged; err<=1.
  - Always go to DONE.
- MUL_ADD:
  - Drive cntrl 000, in1=P, in2=M.
  - If Q[0]: P<=alu_out; ovf|=alu_cout.
  - Go to MUL_SHIFT.
- MUL_SHIFT:
  - Drive cntrl 100, in1=M, in2=1; M<=alu_out; Q<=Q>>1.
  - If alu_cout and (Q>>1)!=0: ovf<=1.
  - If (Q>>1)==0: acc<=P; Z<=(P==0); C<=ovf; V<=0; go to DONE. Otherwise go to MUL_ADD.
- DONE: done=1 for exactly one cycle; err reflects this op; go to IDLE.
- Latency (start sampled at edge t):
  - Single-cycle ops: done high in cycle t+2. Back-to-back issue interval is 3 cycles.
  - MUL: done at t+2k+1, where k = index of operand's highest set bit + 1.
- Result arithmetic is modulo 2^n. MUL is unsigned; C indicates product >= 2^n.
- Non-MUL ALU ops drive idle buses as cntrl 111 with in2=0.

Optional Feature:
- Macro: ACC_ALU_MUL_EN.
- Defined: MUL (1001) is implemented as above.
- Undefined: MUL states are not synthesized; opcode 1001 is illegal (err=1, acc unchanged, done at t+2).

Decomposition:
- Shared package holds:
  - ALU control constants (ALU_ADD..ALU_PASS).
  - Opcode constants (OP_LOAD, OP_MUL).
  - State encoding.
- Natural sub-module: acc_alu_mul_iter, holding the P/M/Q registers, ovf tracking and the iteration-complete flag. The FSM and accumulator stay in the top level.

Test Plan:
- Reset, then LOAD 0x7F followed by ADD 0x01 -> acc=0x80, V=1, C=0, Z=0; done exactly at t+2, busy high t+1..t+2.
- LOAD 0x00, then SUB 0x01 -> acc=0xFF, C=1, Z=0; then AND 0x00 -> acc=0x00, Z=1.
- LOAD 0x0D, MUL 0x0B (ACC_ALU_MUL_EN) -> acc=0x8F, C=0, Z=0, done at t+9. LOAD 0x10, MUL 0x10 -> acc=0x00, Z=1, C=1, done at t+11.
- Pulse start with opcode ADD during a MUL -> ignored; final acc equals the multiply result only.
- Opcode 1111 with acc=0x55 -> err=1, acc=0x55, flags unchanged, done at t+2. Next legal op clears err.
- Assert rst for one cycle mid-MUL -> acc=0, busy=0, done never pulses, flags 0. A fresh LOAD 0x01 then completes normally.

Source files
------------

// File: rtl/acc_alu_sequencer_pkg.sv
// Shared constants for the accumulator/ALU sequencer: ALU control codes, opcodes, FSM states.
// Opcode 1001 (MUL) decodes as legal only when ACC_ALU_MUL_EN is defined.
package acc_alu_sequencer_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SHL  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_MUL_ADD   = 3'd2,
        ST_MUL_SHIFT = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        K_ALU     = 2'd0,
        K_LOAD    = 2'd1,
        K_MUL     = 2'd2,
        K_ILLEGAL = 2'd3
    } op_kind_e;

    function automatic op_kind_e decode_op(input logic [3:0] op);
        if (!op[3]) return K_ALU;
        if (op == OP_LOAD) return K_LOAD;
`ifdef ACC_ALU_MUL_EN
        if (op == OP_MUL) return K_MUL;
`endif
        return K_ILLEGAL;
    endfunction

endpackage

// File: rtl/acc_alu_sequencer_if.sv
// Decode-side handshake, accumulator/flag outputs and ALU buses of the sequencer.
// slave = sequencer view; master = decode/ALU environment view.
interface acc_alu_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic [3:0]   opcode;
    logic [N-1:0] operand;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] acc;
    logic         flag_V;
    logic         flag_Z;
    logic         flag_C;
    logic [2:0]   alu_cntrl;
    logic [N-1:0] alu_in1;
    logic [N-1:0] alu_in2;
    logic [N-1:0] alu_out;
    logic         alu_V;
    logic         alu_Z;
    logic         alu_cout;

    modport slave (
        input  start, opcode, operand, alu_out, alu_V, alu_Z, alu_cout,
        output busy, done, err, acc, flag_V, flag_Z, flag_C, alu_cntrl, alu_in1, alu_in2
    );

    modport master (
        output start, opcode, operand, alu_out, alu_V, alu_Z, alu_cout,
        input  busy, done, err, acc, flag_V, flag_Z, flag_C, alu_cntrl, alu_in1, alu_in2
    );
endinterface

// File: rtl/acc_alu_mul_iter.sv
// Shift-and-add multiply iteration state: partial product P, shifted multiplicand M,
// remaining multiplier Q and overflow tracking. The ALU does the arithmetic; this only holds state.
module acc_alu_mul_iter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_i,
    input  logic [N-1:0] m_init_i,
    input  logic [N-1:0] q_init_i,
    input  logic         add_en_i,
    input  logic         shift_en_i,
    input  logic [N-1:0] alu_out_i,
    input  logic         alu_cout_i,
    output logic [N-1:0] p_o,
    output logic [N-1:0] m_o,
    output logic         ovf_o,
    output logic         last_o
);

    logic [N-1:0] p_q, p_d;
    logic [N-1:0] m_q, m_d;
    logic [N-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;

    // A bit lost from M only matters if a higher multiplier bit will still add it in.
    assign last_o = ((q_q >> 1) == '0);

    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        q_d   = q_q;
        ovf_d = ovf_q;
        if (init_i) begin
            p_d   = '0;
            m_d   = m_init_i;
            q_d   = q_init_i;
            ovf_d = 1'b0;
        end else if (add_en_i) begin
            if (q_q[0]) begin
                p_d   = alu_out_i;
                ovf_d = ovf_q | alu_cout_i;
            end
        end else if (shift_en_i) begin
            m_d = alu_out_i;
            q_d = q_q >> 1;
            if (alu_cout_i && !last_o) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign p_o   = p_q;
    assign m_o   = m_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_alu_sequencer.sv
// Accumulator-machine controller sequencing an external combinational ALU over a start/done handshake.
// Define ACC_ALU_MUL_EN to build the multi-cycle unsigned multiply (opcode 1001); otherwise it is illegal.
module acc_alu_sequencer
    import acc_alu_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input logic                clk,
    input logic                rst,
    acc_alu_sequencer_if.slave bus
);

    state_e       state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] opnd_q, opnd_d;
    logic [N-1:0] acc_q, acc_d;
    logic         v_q, v_d, z_q, z_d, c_q, c_d;
    logic         err_q, err_d;
    op_kind_e     kind;

    assign kind = decode_op(op_q);

`ifdef ACC_ALU_MUL_EN
    logic         mul_init;
    logic [N-1:0] mul_p;
    logic [N-1:0] mul_m;
    logic         mul_ovf;
    logic         mul_last;

    acc_alu_mul_iter #(.N(N)) u_mul_iter (
        .clk        (clk),
        .rst        (rst),
        .init_i     (mul_init),
        .m_init_i   (acc_q),
        .q_init_i   (bus.operand),
        .add_en_i   (state_q == ST_MUL_ADD),
        .shift_en_i (state_q == ST_MUL_SHIFT),
        .alu_out_i  (bus.alu_out),
        .alu_cout_i (bus.alu_cout),
        .p_o        (mul_p),
        .m_o        (mul_m),
        .ovf_o      (mul_ovf),
        .last_o     (mul_last)
    );
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opnd_d        = opnd_q;
        acc_d         = acc_q;
        v_d           = v_q;
        z_d           = z_q;
        c_d           = c_q;
        err_d         = err_q;
        bus.alu_cntrl = ALU_PASS;
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
`ifdef ACC_ALU_MUL_EN
        mul_init      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.opcode;
                    opnd_d  = bus.operand;
                    state_d = ST_EXEC;
`ifdef ACC_ALU_MUL_EN
                    // Multiply by zero finishes in EXEC like any single-cycle op.
                    if (bus.opcode == OP_MUL && bus.operand != '0) begin
                        mul_init = 1'b1;
                        state_d  = ST_MUL_ADD;
                    end
`endif
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                err_d   = 1'b0;
                case (kind)
                    K_ALU: begin
                        bus.alu_cntrl = op_q[2:0];
                        bus.alu_in1   = acc_q;
                        bus.alu_in2   = opnd_q;
                        acc_d         = bus.alu_out;
                        v_d           = bus.alu_V;
                        z_d           = bus.alu_Z;
                        c_d           = bus.alu_cout;
                    end
                    K_LOAD: begin
                        bus.alu_in1 = opnd_q;
                        acc_d       = opnd_q;
                        z_d         = bus.alu_Z;
                        v_d         = 1'b0;
                        c_d         = 1'b0;
                    end
                    K_MUL: begin
                        acc_d = '0;
                        z_d   = 1'b1;
                        v_d   = 1'b0;
                        c_d   = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
`ifdef ACC_ALU_MUL_EN
            ST_MUL_ADD: begin
                bus.alu_cntrl = ALU_ADD;
                bus.alu_in1   = mul_p;
                bus.alu_in2   = mul_m;
                state_d       = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                bus.alu_cntrl = ALU_SHL;
                bus.alu_in1   = mul_m;
                bus.alu_in2   = N'(1);
                state_d       = ST_MUL_ADD;
                if (mul_last) begin
                    acc_d   = mul_p;
                    z_d     = (mul_p == '0);
                    c_d     = mul_ovf;
                    v_d     = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            v_q     <= v_d;
            z_q     <= z_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.acc    = acc_q;
    assign bus.flag_V = v_q;
    assign bus.flag_Z = z_q;
    assign bus.flag_C = c_q;

endmodule

// File: tb/tb_acc_alu_sequencer.sv
// Bench for acc_alu_sequencer: behavioural ALU, op-level reference model and per-cycle compare.
module tb_acc_alu_sequencer;
    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] out;
        logic         v;
        logic         z;
        logic         c;
    } alu_res_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] cur_acc, nxt_acc;
    logic       cur_v, cur_z, cur_c, cur_err;
    logic       nxt_v, nxt_z, nxt_c, nxt_err;
    logic       pending;
    logic       at_done;
    int         s_cyc, d_cyc, last_done, t0;
    alu_res_t   alu_r;

    acc_alu_sequencer_if #(.N(N)) bus ();
    acc_alu_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic alu_res_t alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        alu_res_t r;
        logic [8:0] w;
        int sh;
        r  = '0;
        sh = int'(b);
        case (c)
            3'd0: begin
                w     = {1'b0, a} + {1'b0, b};
                r.out = w[7:0];
                r.c   = w[8];
                r.v   = (a[7] == b[7]) && (r.out[7] != a[7]);
            end
            3'd1: begin
                r.out = a - b;
                r.c   = (a < b);
                r.v   = (a[7] != b[7]) && (r.out[7] != a[7]);
            end
            3'd2: r.out = a | b;
            3'd3: r.out = a & b;
            3'd4: begin
                r.out = a << b;
                if (sh >= 1 && sh <= 8) r.c = a[8 - sh];
            end
            3'd5: r.out = a >> b;
            3'd6: r.out = ~a;
            default: r.out = a;
        endcase
        r.z = (r.out == 8'h00);
        return r;
    endfunction

    always_comb alu_r = alu_f(bus.alu_cntrl, bus.alu_in1, bus.alu_in2);
    assign bus.alu_out  = alu_r.out;
    assign bus.alu_V    = alu_r.v;
    assign bus.alu_Z    = alu_r.z;
    assign bus.alu_cout = alu_r.c;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the op-level model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_acc", int'(bus.acc), 0);
            chk("rst_flags_err", int'({bus.flag_V, bus.flag_Z, bus.flag_C, bus.err}), 0);
            chk("rst_alu_bus", int'({bus.alu_cntrl, bus.alu_in1, bus.alu_in2}), 'h70000);
        end else begin
            at_done = pending && (cyc == d_cyc);
            chk("busy", int'(bus.busy), int'(pending && cyc > s_cyc && cyc <= d_cyc));
            chk("done", int'(bus.done), int'(at_done));
            if (at_done) begin
                cur_acc   = nxt_acc;
                cur_v     = nxt_v;
                cur_z     = nxt_z;
                cur_c     = nxt_c;
                cur_err   = nxt_err;
                pending   = 1'b0;
                last_done = cyc;
            end
            chk("acc", int'(bus.acc), int'(cur_acc));
            chk("flags_vzc", int'({bus.flag_V, bus.flag_Z, bus.flag_C}), int'({cur_v, cur_z, cur_c}));
            chk("err", int'(bus.err), int'(cur_err));
        end
    end

    // Called just after a rising edge with the DUT idle; start is sampled on the next edge.
    task automatic issue(input logic [3:0] opc, input logic [7:0] opd);
        alu_res_t r;
        logic [15:0] prod;
        int k;
        s_cyc   = cyc;
        d_cyc   = cyc + 2;
        nxt_acc = cur_acc;
        nxt_v   = cur_v;
        nxt_z   = cur_z;
        nxt_c   = cur_c;
        nxt_err = 1'b0;
        if (!opc[3]) begin
            r       = alu_f(opc[2:0], cur_acc, opd);
            nxt_acc = r.out;
            nxt_v   = r.v;
            nxt_z   = r.z;
            nxt_c   = r.c;
        end else if (opc == 4'b1000) begin
            nxt_acc = opd;
            nxt_z   = (opd == 8'h00);
            nxt_v   = 1'b0;
            nxt_c   = 1'b0;
        end
`ifdef ACC_ALU_MUL_EN
        else if (opc == 4'b1001) begin
            prod    = 16'(cur_acc) * 16'(opd);
            nxt_acc = prod[7:0];
            nxt_c   = (prod > 16'h00FF);
            nxt_z   = (prod[7:0] == 8'h00);
            nxt_v   = 1'b0;
            k = 0;
            for (int i = 0; i < 8; i++) if (opd[i]) k = i + 1;
            if (k != 0) d_cyc = s_cyc + 2 * k + 1;
        end
`endif
        else begin
            nxt_err = 1'b1;
        end
        pending     = 1'b1;
        bus.start   = 1'b1;
        bus.opcode  = opc;
        bus.operand = opd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pending && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pending) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%0d after %0d cycles, expected done pulse", bus.busy, n);
            pending = 1'b0;
        end
    endtask

    task automatic run_op(input logic [3:0] opc, input logic [7:0] opd);
        issue(opc, opd);
        t0 = s_cyc;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.opcode = 4'h0;
        bus.operand = 8'h00;
        pending = 1'b0;
        cur_acc = 8'h00; cur_v = 1'b0; cur_z = 1'b0; cur_c = 1'b0; cur_err = 1'b0;
        nxt_acc = 8'h00; nxt_v = 1'b0; nxt_z = 1'b0; nxt_c = 1'b0; nxt_err = 1'b0;
        s_cyc = 0; d_cyc = 0; last_done = 0; t0 = 0; at_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_reset_acc", int'(bus.acc), 0);
        chk("lit_reset_cntrl", int'(bus.alu_cntrl), 7);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(4'b1000, 8'h7F);
        run_op(4'b0000, 8'h01);
        chk("lit_add_acc", int'(bus.acc), 'h80);
        chk("lit_add_vzc", int'({bus.flag_V, bus.flag_Z, bus.flag_C}), 'b100);
        chk("lit_add_latency", last_done - t0, 2);

        run_op(4'b1000, 8'h00);
        run_op(4'b0001, 8'h01);
        chk("lit_sub_acc", int'(bus.acc), 'hFF);
        chk("lit_sub_zc", int'({bus.flag_Z, bus.flag_C}), 'b01);
        run_op(4'b0011, 8'h00);
        chk("lit_and_acc", int'(bus.acc), 0);
        chk("lit_and_z", int'(bus.flag_Z), 1);

        run_op(4'b1000, 8'h0D);
        run_op(4'b1001, 8'h0B);
`ifdef ACC_ALU_MUL_EN
        chk("lit_mul_acc", int'(bus.acc), 'h8F);
        chk("lit_mul_zc", int'({bus.flag_Z, bus.flag_C}), 'b00);
        chk("lit_mul_latency", last_done - t0, 9);
`else
        chk("lit_mul_off_acc", int'(bus.acc), 'h0D);
        chk("lit_mul_off_err", int'(bus.err), 1);
        chk("lit_mul_off_latency", last_done - t0, 2);
`endif

        run_op(4'b1000, 8'h10);
        run_op(4'b1001, 8'h10);
`ifdef ACC_ALU_MUL_EN
        chk("lit_mul_ovf_acc", int'(bus.acc), 0);
        chk("lit_mul_ovf_zc", int'({bus.flag_Z, bus.flag_C}), 'b11);
        chk("lit_mul_ovf_latency", last_done - t0, 11);
`else
        chk("lit_mul_off2_acc", int'(bus.acc), 'h10);
`endif

        // start while busy must be dropped
        run_op(4'b1000, 8'h03);
        issue(4'b1001, 8'h05);
        bus.start   = 1'b1;
        bus.opcode  = 4'b0000;
        bus.operand = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
`ifdef ACC_ALU_MUL_EN
        chk("lit_ignored_start_acc", int'(bus.acc), 'h0F);
`else
        chk("lit_ignored_start_acc", int'(bus.acc), 'h03);
`endif

        run_op(4'b1000, 8'hFF);
        run_op(4'b0000, 8'h56);
        run_op(4'b1111, 8'h12);
        chk("lit_illegal_acc", int'(bus.acc), 'h55);
        chk("lit_illegal_err", int'(bus.err), 1);
        chk("lit_illegal_vzc", int'({bus.flag_V, bus.flag_Z, bus.flag_C}), 'b001);
        chk("lit_illegal_latency", last_done - t0, 2);
        run_op(4'b0010, 8'h0A);
        chk("lit_err_cleared", int'(bus.err), 0);
        chk("lit_or_acc", int'(bus.acc), 'h5F);

        // reset in the middle of an operation
        run_op(4'b1000, 8'h03);
        issue(4'b1001, 8'h0F);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pending = 1'b0;
        cur_acc = 8'h00; cur_v = 1'b0; cur_z = 1'b0; cur_c = 1'b0; cur_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("lit_midrst_acc", int'(bus.acc), 0);
        chk("lit_midrst_busy", int'(bus.busy), 0);
        run_op(4'b1000, 8'h01);
        chk("lit_post_rst_load", int'(bus.acc), 1);
        chk("lit_post_rst_latency", last_done - t0, 2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
